operand_forwarder: RTL
======================

// Module: operand_forwarder
// PURPOSE
//  Registered, parametrised successor of the issue-side operand comparator. Sits between
//  decode/rename and the reservation stations. Looks up source operands in the register
//  file and forwards results from NUM_CDB common data buses.
//  Holds up to DEPTH instructions while issue stalls. Held entries keep snooping the CDBs,
//  so an operand that completes during a stall is still captured.
// PARAMETERS
//  XLEN      32  data width of operands and CDB results
//  REG_W     6   width of arn/rrn/rs tags (0 = hard-wired zero register)
//  NUM_CDB   2   number of CDB channels snooped
//  DEPTH     2   holding-buffer entries (power of two, >=2)
//  INFO_W    96  opaque payload width (address, immediate, name, type, flags, rd)
// PORTS
//  clk          in   1              clock, rising edge
//  reset        in   1              synchronous, active-high
//  in_valid     in   1              upstream instruction valid
//  in_ready     out  1              buffer can accept this cycle
//  in_info      in   INFO_W         payload, passed through untouched
//  in_rs_1      in   REG_W          source tag 1
//  in_rs_2      in   REG_W          source tag 2
//  rf_src_1     out  REG_W          register-file read tag 1 (= in_rs_1)
//  rf_src_2     out  REG_W          register-file read tag 2 (= in_rs_2)
//  rf_data_1    in   XLEN           register-file value 1 (same cycle)
//  rf_data_2    in   XLEN           register-file value 2
//  rf_valid_1   in   1              value 1 ready in register file
//  rf_valid_2   in   1              value 2 ready in register file
//  cdb_valid    in   NUM_CDB        per-channel broadcast valid
//  cdb_arn      in   NUM_CDB*REG_W  per-channel architectural tag
//  cdb_rrn      in   NUM_CDB*REG_W  per-channel rename tag
//  cdb_result   in   NUM_CDB*XLEN   per-channel result
//  out_valid    out  1              head entry valid toward issue
//  out_ready    in   1              issue accepts head entry
//  out_info     out  INFO_W         head payload
//  out_rs_1     out  REG_W          head source tag 1
//  out_rs_2     out  REG_W          head source tag 2
//  out_data_1   out  XLEN           head operand 1
//  out_data_2   out  XLEN           head operand 2
//  out_ok_1     out  1              operand 1 valid
//  out_ok_2     out  1              operand 2 valid
//  flush        in   1              discard all held entries (mispredict)
// BEHAVIOUR
//  - Reset: all entries invalid, head/tail pointers 0, count 0. out_valid=0, in_ready=1.
//    All out_* data/tag/ok fields reset to 0.
//  - Capture (in_valid & in_ready): operand x is resolved in this priority order:
//    1. CDB hit: rs_x!=0, cdb_valid[k], and rs_x==arn[k] or rs_x==rrn[k].
//       Lowest k wins. Take cdb_result[k]; ok_x=1.
//    2. Otherwise take rf_data_x / rf_valid_x.
//    rs_x==0 never hits a CDB; it takes the register file (value 0, valid).
//  - Latency: a captured entry appears on out_* the next cycle at the earliest.
//    No combinational path from in_* to out_*.
//  - Snoop: every cycle, each held entry with ok_x=0 applies the same hit rule to the CDBs.
//    On a hit it latches the data and sets ok_x=1. ok_x never drops while the entry is held.
//  - Same-cycle snoop and pop: if the head pops while a CDB hits it, the entry leaves with
//    its pre-edge values. The update is lost; the RS snoops the same bus.
//  - FIFO: pop on out_valid & out_ready. in_ready = (count<DEPTH) | (out_ready & out_valid).
//    Push and pop may both happen when full. Pointers wrap modulo DEPTH.
//  - Ordering: strictly in-order, no bypass around held entries.
//  - Flush: has priority over push and pop. Next cycle count=0 and out_valid=0.
//    An instruction offered in the flush cycle is dropped. in_ready stays asserted.
//  - out_valid does not depend on ok_1/ok_2. Issue may take entries with pending operands.
// STRUCTURE
//  - pkg_defines gets: typedef fwd_entry_t {info, rs_1, rs_2, data_1, data_2, ok_1, ok_2, valid}
//    and function cdb_match(rs, valid, arn, rrn), which returns hit and index.
//  - One sub-module, cdb_snoop_unit: combinational priority match of one tag against
//    NUM_CDB channels. Instantiated 2 for capture plus 2*DEPTH for the held entries.
// TESTING
//  1. Reset, rf_valid=1, rf_data_1=0x11, rs_1=3, no CDB -> next cycle out_data_1=0x11, ok_1=1.
//  2. rs_1=5, cdb_valid=2'b11, both channels arn=5, results 0xA/0xB
//     -> out_data_1=0xA (channel 0 wins).
//  3. rs_2=0, cdb arn[0]=0 valid, rf_data_2=0 -> out_data_2=0, ok_2=1, no forward.
//  4. out_ready=0, entry has ok_1=0 with rs_1=7. Cycle later cdb rrn[1]=7, result 0x55
//     -> out_data_1=0x55, ok_1=1; entry held until out_ready.
//  5. Fill DEPTH entries with out_ready=0 -> in_ready=0. Then out_ready=1 plus a new push
//     -> one pop and one push same cycle; order preserved across wrap.
//  6. flush with 2 held entries and in_valid=1 -> next cycle out_valid=0 and count=0.
//     Offered instruction never appears.

Source files
------------

// File: rtl/operand_forwarder_pkg.sv
// Shared widths, the held-entry record and the CDB tag-match rule used by
// every lookup in the operand forwarder.
package operand_forwarder_pkg;

    localparam int XLEN      = 32;
    localparam int REG_W     = 6;
    localparam int NUM_CDB   = 2;
    localparam int DEPTH     = 2;
    localparam int INFO_W    = 96;
    localparam int CDB_IDX_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [INFO_W-1:0] info;
        logic [REG_W-1:0]  rs_1;
        logic [REG_W-1:0]  rs_2;
        logic [XLEN-1:0]   data_1;
        logic [XLEN-1:0]   data_2;
        logic              ok_1;
        logic              ok_2;
        logic              valid;
    } fwd_entry_t;

    typedef struct packed {
        logic                 hit;
        logic [CDB_IDX_W-1:0] idx;
    } cdb_hit_t;

    // Tag 0 is the zero register and never matches; the lowest channel wins.
    function automatic cdb_hit_t cdb_match(input logic [REG_W-1:0]         rs,
                                           input logic [NUM_CDB-1:0]       valid,
                                           input logic [NUM_CDB*REG_W-1:0] arn,
                                           input logic [NUM_CDB*REG_W-1:0] rrn);
        cdb_hit_t r;
        r = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if ((rs != '0) && valid[k] &&
                ((rs == arn[k*REG_W +: REG_W]) || (rs == rrn[k*REG_W +: REG_W]))) begin
                r.hit = 1'b1;
                r.idx = CDB_IDX_W'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/operand_forwarder_cdb_snoop_unit.sv
// Combinational priority match of one source tag against all CDB channels,
// returning the winning channel's result.
module cdb_snoop_unit
    import operand_forwarder_pkg::*;
(
    input  logic [REG_W-1:0]         tag_i,
    input  logic [NUM_CDB-1:0]       cdb_valid_i,
    input  logic [NUM_CDB*REG_W-1:0] cdb_arn_i,
    input  logic [NUM_CDB*REG_W-1:0] cdb_rrn_i,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_result_i,
    output logic                     hit_o,
    output logic [XLEN-1:0]          data_o
);

    cdb_hit_t match;

    always_comb begin
        match  = cdb_match(tag_i, cdb_valid_i, cdb_arn_i, cdb_rrn_i);
        hit_o  = match.hit;
        data_o = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (match.idx == CDB_IDX_W'(k)) begin
                data_o = cdb_result_i[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/operand_forwarder.sv
// Registered operand lookup and CDB forwarding between rename and the
// reservation stations; a small in-order FIFO keeps snooping while issue stalls.
module operand_forwarder
    import operand_forwarder_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INFO_W-1:0]        in_info,
    input  logic [REG_W-1:0]         in_rs_1,
    input  logic [REG_W-1:0]         in_rs_2,
    output logic [REG_W-1:0]         rf_src_1,
    output logic [REG_W-1:0]         rf_src_2,
    input  logic [XLEN-1:0]          rf_data_1,
    input  logic [XLEN-1:0]          rf_data_2,
    input  logic                     rf_valid_1,
    input  logic                     rf_valid_2,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*REG_W-1:0] cdb_arn,
    input  logic [NUM_CDB*REG_W-1:0] cdb_rrn,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INFO_W-1:0]        out_info,
    output logic [REG_W-1:0]         out_rs_1,
    output logic [REG_W-1:0]         out_rs_2,
    output logic [XLEN-1:0]          out_data_1,
    output logic [XLEN-1:0]          out_data_2,
    output logic                     out_ok_1,
    output logic                     out_ok_2,
    input  logic                     flush
);

    fwd_entry_t       ent_q [DEPTH];
    fwd_entry_t       ent_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             cap_hit_1, cap_hit_2;
    logic [XLEN-1:0]  cap_data_1, cap_data_2;
    fwd_entry_t       cap_e;
    logic [DEPTH-1:0] held_hit_1, held_hit_2;
    logic [XLEN-1:0]  held_data_1 [DEPTH];
    logic [XLEN-1:0]  held_data_2 [DEPTH];
    logic             pop_req, push, pop;

    assign rf_src_1 = in_rs_1;
    assign rf_src_2 = in_rs_2;

    cdb_snoop_unit u_cap_1 (.tag_i(in_rs_1), .cdb_valid_i(cdb_valid), .cdb_arn_i(cdb_arn),
                            .cdb_rrn_i(cdb_rrn), .cdb_result_i(cdb_result),
                            .hit_o(cap_hit_1), .data_o(cap_data_1));
    cdb_snoop_unit u_cap_2 (.tag_i(in_rs_2), .cdb_valid_i(cdb_valid), .cdb_arn_i(cdb_arn),
                            .cdb_rrn_i(cdb_rrn), .cdb_result_i(cdb_result),
                            .hit_o(cap_hit_2), .data_o(cap_data_2));

    for (genvar g = 0; g < DEPTH; g++) begin : g_held
        cdb_snoop_unit u_snoop_1 (.tag_i(ent_q[g].rs_1), .cdb_valid_i(cdb_valid),
                                  .cdb_arn_i(cdb_arn), .cdb_rrn_i(cdb_rrn),
                                  .cdb_result_i(cdb_result),
                                  .hit_o(held_hit_1[g]), .data_o(held_data_1[g]));
        cdb_snoop_unit u_snoop_2 (.tag_i(ent_q[g].rs_2), .cdb_valid_i(cdb_valid),
                                  .cdb_arn_i(cdb_arn), .cdb_rrn_i(cdb_rrn),
                                  .cdb_result_i(cdb_result),
                                  .hit_o(held_hit_2[g]), .data_o(held_data_2[g]));
    end

    // Handshake: a transfer happens on valid & ready at the rising edge;
    // in_ready may depend on out_ready so a full buffer can pop and push together.
    assign out_valid = (count_q != '0);
    assign pop_req   = out_valid & out_ready;
    assign in_ready  = (count_q < FULL_CNT) | pop_req;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = pop_req & ~flush;

    assign out_info   = ent_q[head_q].info;
    assign out_rs_1   = ent_q[head_q].rs_1;
    assign out_rs_2   = ent_q[head_q].rs_2;
    assign out_data_1 = ent_q[head_q].data_1;
    assign out_data_2 = ent_q[head_q].data_2;
    assign out_ok_1   = ent_q[head_q].ok_1;
    assign out_ok_2   = ent_q[head_q].ok_2;

    always_comb begin
        cap_e        = '0;
        cap_e.info   = in_info;
        cap_e.rs_1   = in_rs_1;
        cap_e.rs_2   = in_rs_2;
        cap_e.data_1 = cap_hit_1 ? cap_data_1 : rf_data_1;
        cap_e.data_2 = cap_hit_2 ? cap_data_2 : rf_data_2;
        cap_e.ok_1   = cap_hit_1 | rf_valid_1;
        cap_e.ok_2   = cap_hit_2 | rf_valid_2;
        cap_e.valid  = 1'b1;
    end

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && !ent_q[i].ok_1 && held_hit_1[i]) begin
                ent_d[i].data_1 = held_data_1[i];
                ent_d[i].ok_1   = 1'b1;
            end
            if (ent_q[i].valid && !ent_q[i].ok_2 && held_hit_2[i]) begin
                ent_d[i].data_2 = held_data_2[i];
                ent_d[i].ok_2   = 1'b1;
            end
        end
        // A popping head leaves with its pre-edge operands; its snoop result is discarded.
        if (pop) begin
            ent_d[head_q].valid = 1'b0;
            head_d              = head_q + PTR_W'(1);
        end
        if (push) begin
            ent_d[tail_q] = cap_e;
            tail_d        = tail_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
